// File: rtl/dsp_sop_pkg.sv
// Shared constants and FSM state type for the SOP result drain.
// The SUM state exists only when DSP_DRAIN_SUM_EN is defined.
package dsp_sop_pkg;

    localparam int LANES_DEF  = 8;
    localparam int LANE_W_DEF = 37;
    localparam int LANE_IDX_W = 4;

`ifdef DSP_DRAIN_SUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SUM   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/dsp_sop_lane_sum.sv
// Combinational adder tree summing LANES lanes of LANE_W bits, modulo 2^LANE_W.
// Leaves are padded with zeros up to the next power of two.
module dsp_sop_lane_sum #(
    parameter int LANES  = 8,
    parameter int LANE_W = 37
) (
    input  logic [LANES*LANE_W-1:0] data_i,
    output logic [LANE_W-1:0]       sum_o
);

    localparam int P = 1 << $clog2(LANES);

    // Heap layout: node[1] is the root, node[P..2P-1] are the leaves.
    logic [LANE_W-1:0] node [2*P];

    always_comb begin
        for (int i = 0; i < 2*P; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            node[P+i] = data_i[i*LANE_W +: LANE_W];
        end
        for (int i = P-1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
    end

    assign sum_o = node[1];

endmodule

// File: rtl/dsp_sop_result_drain.sv
// Serialises a packed vector of SOP results into one lane per beat.
// Optional feature macro DSP_DRAIN_SUM_EN appends a beat carrying the lane sum.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// DRAIN | emitting held lane[cnt_q]
// SUM   | emitting registered lane sum (DSP_DRAIN_SUM_EN only)
module dsp_sop_result_drain
    import dsp_sop_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [LANE_W-1:0]       out_data,
    output logic [3:0]              out_lane,
    output logic                    out_last,
    input  logic                    out_ready
);

    state_t                    state_q, state_d;
    logic [LANE_IDX_W-1:0]     cnt_q, cnt_d;
    logic [LANES*LANE_W-1:0]   hold_q;
    logic                      load;
    logic                      last_lane;

    assign last_lane = (cnt_q == LANE_IDX_W'(LANES-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                hold_q <= in_data;
            end
        end
    end

`ifdef DSP_DRAIN_SUM_EN
    logic [LANE_W-1:0] sum_d, sum_q;

    dsp_sop_lane_sum #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_sum (
        .data_i (in_data),
        .sum_o  (sum_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (load) begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_lane  = '0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = hold_q[int'(cnt_q)*LANE_W +: LANE_W];
                out_lane  = cnt_q;
`ifdef DSP_DRAIN_SUM_EN
                if (out_ready) begin
                    cnt_d = cnt_q + LANE_IDX_W'(1);
                    if (last_lane) begin
                        state_d = SUM;
                    end
                end
`else
                out_last = last_lane;
                if (out_ready) begin
                    cnt_d = cnt_q + LANE_IDX_W'(1);
                    // Final beat: accept the next vector in the same cycle.
                    if (last_lane) begin
                        in_ready = 1'b1;
                        state_d  = IDLE;
                        if (in_valid) begin
                            load    = 1'b1;
                            cnt_d   = '0;
                            state_d = DRAIN;
                        end
                    end
                end
`endif
            end
`ifdef DSP_DRAIN_SUM_EN
            SUM: begin
                out_valid = 1'b1;
                out_data  = sum_q;
                out_lane  = 4'(LANES);
                out_last  = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = IDLE;
                    if (in_valid) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs read as zero for the whole time reset is held.
        if (reset) begin
            load      = 1'b0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            out_lane  = '0;
            out_last  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_sop_result_drain.sv
// Directed, table-driven bench for dsp_sop_result_drain; SUM beat checks follow DSP_DRAIN_SUM_EN.
module tb_dsp_sop_result_drain;

    localparam int LANES  = 8;
    localparam int LANE_W = 37;
`ifdef DSP_DRAIN_SUM_EN
    localparam int NB = LANES + 1;
`else
    localparam int NB = LANES;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic [LANES*LANE_W-1:0] in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic [LANE_W-1:0]       out_data;
    logic [3:0]              out_lane;
    logic                    out_last;
    logic                    out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LANES-1:0][LANE_W-1:0] lanes;
        logic [LANE_W-1:0]            sum;
    } vec_t;

    vec_t vecs [3];

    dsp_sop_result_drain #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANE_W-1:0] exp_data(input int v, input int b);
        if (b < LANES) return vecs[v].lanes[b];
        return vecs[v].sum;
    endfunction

    task automatic check_beat(input string tag, input int v, input int b, input logic exp_rdy);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(1));
        chk({tag, " out_data"},  64'(out_data),  64'(exp_data(v, b)));
        chk({tag, " out_lane"},  64'(out_lane),  64'(b));
        chk({tag, " out_last"},  64'(out_last),  64'(b == NB-1));
        chk({tag, " in_ready"},  64'(in_ready),  64'(exp_rdy));
    endtask

    task automatic capture(input int v);
        in_valid  = 1'b1;
        in_data   = vecs[v].lanes;
        out_ready = 1'b1;
        #1;
        chk("idle in_ready", 64'(in_ready), 64'(1));
        chk("idle out_valid", 64'(out_valid), 64'(0));
        step();
        in_valid = 1'b0;
        in_data  = '0;
        #1;
    endtask

    initial begin
        vecs[0].lanes = {37'd8, 37'd7, 37'd6, 37'd5, 37'd4, 37'd3, 37'd2, 37'd1};
        vecs[0].sum   = 37'h24;
        vecs[1].lanes = {8{37'h1FFFFFFFFF}};
        vecs[1].sum   = 37'h1FFFFFFFF8;
        vecs[2].lanes = {37'h0, 37'h123456789, 37'd7, 37'h1FFFFFFFFE,
                         37'h0, 37'd5, 37'h0FFFFFFFFF, 37'h1000000000};
        vecs[2].sum   = 37'h0123456792;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst in_ready", 64'(in_ready), 64'(0));
        chk("rst out_valid", 64'(out_valid), 64'(0));
        step(); step();
        reset = 1'b0;
        #1;
        // Idle hold after reset.
        for (int c = 0; c < 10; c++) begin
            chk("idle10 out_valid", 64'(out_valid), 64'(0));
            chk("idle10 in_ready", 64'(in_ready), 64'(1));
            step();
        end

        // Table vectors with out_ready held high.
        for (int v = 0; v < 3; v++) begin
            capture(v);
            for (int b = 0; b < NB; b++) begin
                check_beat("vec", v, b, b == NB-1);
                step();
            end
            chk("vec end out_valid", 64'(out_valid), 64'(0));
        end

        // Backpressure on lane 3, with a competing in_valid that must be ignored.
        capture(0);
        for (int b = 0; b < 3; b++) begin
            check_beat("pre-stall", 0, b, 1'b0);
            step();
        end
        out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[1].lanes;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_beat("stall", 0, 3, 1'b0);
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
        #1;
        for (int b = 3; b < NB; b++) begin
            check_beat("post-stall", 0, b, b == NB-1);
            step();
        end
        chk("post-stall idle", 64'(out_valid), 64'(0));

        // Back-to-back vectors: second captured on the final beat, no gap.
        in_valid = 1'b1; in_data = vecs[0].lanes; out_ready = 1'b1;
        step();
        in_data = vecs[2].lanes;
        #1;
        for (int b = 0; b < 2*NB; b++) begin
            if (b == NB) begin
                in_valid = 1'b0;
                #1;
            end
            check_beat("b2b", (b < NB) ? 0 : 2, b % NB, (b % NB) == NB-1);
            step();
        end
        chk("b2b end out_valid", 64'(out_valid), 64'(0));

        // Reset while lane 5 is presented.
        capture(2);
        for (int b = 0; b < 5; b++) begin
            check_beat("pre-rst", 2, b, 1'b0);
            step();
        end
        reset = 1'b1;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'(0));
        chk("midrst out_last", 64'(out_last), 64'(0));
        chk("midrst out_lane", 64'(out_lane), 64'(0));
        chk("midrst out_data", 64'(out_data), 64'(0));
        chk("midrst in_ready", 64'(in_ready), 64'(0));
        step();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("postrst in_ready", 64'(in_ready), 64'(1));
            chk("postrst out_valid", 64'(out_valid), 64'(0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
